// File: rtl/mux_seq_pkg.sv
// Shared state/mode encodings and the pattern code function for the mux test sequencer.
package mux_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BREAK  = 3'd1,
        S_UPDATE = 3'd2,
        S_MAKE   = 3'd3,
        S_DWELL  = 3'd4
    } seq_state_e;

    localparam logic [1:0] M_BIN  = 2'b00;
    localparam logic [1:0] M_GRAY = 2'b01;
    localparam logic [1:0] M_WALK = 2'b10;
    localparam logic [1:0] M_HOLD = 2'b11;

    // Walking-one codes are derived in the caller; every other mode is binary or gray.
    function automatic logic [31:0] pattern_code(input logic [31:0] idx, input logic [1:0] mode);
        logic [31:0] code;
        case (mode)
            M_GRAY:  code = idx ^ (idx >> 1);
            default: code = idx;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the BREAK, MAKE and DWELL phases.
module seq_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tc,
    output logic          pre_tc
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (count_q != '0)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    // pre_tc lets the caller register a pulse that lands on the final counted cycle.
    assign tc     = (count_q == '0);
    assign pre_tc = (count_q == CW'(1));

endmodule

// File: rtl/mux_test_sequencer.sv
// Steps analog-mux addresses, enables and switch controls through binary, gray or
// walking-one patterns with break-before-make guards and sense sampling per step.
module mux_test_sequencer
    import mux_seq_pkg::*;
#(
    parameter int NCH       = 3,
    parameter int ABITS     = 3,
    parameter int SWBITS    = 4,
    parameter int IDXW      = 4,
    parameter int LOG2DELAY = 21,
    parameter int SETTLE    = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 RUN,
    input  logic                 STEP,
    input  logic [1:0]           MODE,
    input  logic                 SENSE,
    output logic [NCH-1:0]       MUX_EN,
    output logic [NCH*ABITS-1:0] MUX_A,
    output logic [SWBITS-1:0]    SW_CTL,
    output logic                 OE_4094,
    output logic [7:0]           SENSE_HIST,
    output logic                 STEP_DONE,
    output logic                 LED,
    output logic [3:0]           MON
);

    localparam int CW = ((LOG2DELAY > $clog2(SETTLE)) ? LOG2DELAY : $clog2(SETTLE)) + 1;
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] DWELL_LD  = CW'((64'd1 << LOG2DELAY) - 64'd1);
    localparam logic [31:0]   IDX_MASK  = (32'd1 << IDXW) - 32'd1;

    seq_state_e             state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [NCH-1:0]         mux_en_q, mux_en_d;
    logic [NCH*ABITS-1:0]   mux_a_q, mux_a_d;
    logic [SWBITS-1:0]      sw_q, sw_d;
    logic                   oe_q, oe_d;
    logic [7:0]             hist_q, hist_d;
    logic                   done_q, done_d;
    logic                   led_q, led_d;
    logic                   sync1_q, sync2_q;

    logic                   tmr_load;
    logic [CW-1:0]          tmr_val;
    logic                   tmr_tc, tmr_pre_tc;

    seq_timer #(.CW(CW)) u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc),
        .pre_tc   (tmr_pre_tc)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mux_en_d = mux_en_q;
        mux_a_d  = mux_a_q;
        sw_d     = sw_q;
        oe_d     = oe_q;
        hist_d   = hist_q;
        done_d   = 1'b0;
        led_d    = led_q;
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LD;

        case (state_q)
            S_IDLE: begin
                if (RUN || STEP) begin
                    state_d  = S_BREAK;
                    tmr_load = 1'b1;
                    mux_en_d = '0;
                end
            end
            S_BREAK: begin
                if (tmr_tc) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                // Hold mode freezes both the codes and the index.
                if (MODE != M_HOLD) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (MODE == M_WALK)
                            mux_a_d[k*ABITS +: ABITS] = ABITS'(32'(idx_q) + 32'(k));
                        else
                            mux_a_d[k*ABITS +: ABITS] =
                                ABITS'(pattern_code((32'(idx_q) + 32'(k)) & IDX_MASK, MODE));
                    end
                    if (MODE == M_WALK)
                        sw_d = SWBITS'(32'd1 << (32'(idx_q) % 32'(SWBITS)));
                    else
                        sw_d = SWBITS'(pattern_code(32'(idx_q), MODE));
                    idx_d = idx_q + IDXW'(1);
                end
                led_d    = ~led_q;
                state_d  = S_MAKE;
                tmr_load = 1'b1;
            end
            S_MAKE: begin
                if (tmr_tc) begin
                    state_d  = S_DWELL;
                    tmr_load = 1'b1;
                    tmr_val  = DWELL_LD;
                    mux_en_d = '1;
                    oe_d     = 1'b1;
                    if (LOG2DELAY == 0) done_d = 1'b1;
                end
            end
            S_DWELL: begin
                if (tmr_pre_tc) done_d = 1'b1;
                if (tmr_tc) begin
                    hist_d = {hist_q[6:0], sync2_q};
                    if (RUN) begin
                        state_d  = S_BREAK;
                        tmr_load = 1'b1;
                        mux_en_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            mux_en_q <= '0;
            mux_a_q  <= '0;
            sw_q     <= '0;
            oe_q     <= 1'b0;
            hist_q   <= '0;
            done_q   <= 1'b0;
            led_q    <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mux_en_q <= mux_en_d;
            mux_a_q  <= mux_a_d;
            sw_q     <= sw_d;
            oe_q     <= oe_d;
            hist_q   <= hist_d;
            done_q   <= done_d;
            led_q    <= led_d;
            sync1_q  <= SENSE;
            sync2_q  <= sync1_q;
        end
    end

    assign MUX_EN     = mux_en_q;
    assign MUX_A      = mux_a_q;
    assign SW_CTL     = sw_q;
    assign OE_4094    = oe_q;
    assign SENSE_HIST = hist_q;
    assign STEP_DONE  = done_q;
    assign LED        = led_q;
    assign MON        = {led_q, state_q};

endmodule

// File: tb/tb_mux_test_sequencer.sv
// Scoreboard bench: stimulus pushes expected step results, a monitor checks at STEP_DONE.
module tb_mux_test_sequencer;

    localparam int NCH = 3, ABITS = 3, SWBITS = 4, IDXW = 3, LOG2DELAY = 2, SETTLE = 2;

    logic CLK = 1'b0, RST_N = 1'b0, RUN = 1'b0, STEP = 1'b0, SENSE = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic [NCH-1:0]       MUX_EN;
    logic [NCH*ABITS-1:0] MUX_A;
    logic [SWBITS-1:0]    SW_CTL;
    logic                 OE_4094, STEP_DONE, LED;
    logic [7:0]           SENSE_HIST;
    logic [3:0]           MON;

    mux_test_sequencer #(
        .NCH(NCH), .ABITS(ABITS), .SWBITS(SWBITS), .IDXW(IDXW),
        .LOG2DELAY(LOG2DELAY), .SETTLE(SETTLE)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .STEP(STEP), .MODE(MODE), .SENSE(SENSE),
        .MUX_EN(MUX_EN), .MUX_A(MUX_A), .SW_CTL(SW_CTL), .OE_4094(OE_4094),
        .SENSE_HIST(SENSE_HIST), .STEP_DONE(STEP_DONE), .LED(LED), .MON(MON)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NCH*ABITS-1:0] a;
        logic [SWBITS-1:0]    sw;
        logic                 led;
        logic [7:0]           hist;
    } exp_t;

    exp_t exp_q[$];
    int total = 0, bad = 0;

    // Reference model state
    int                   m_idx = 0;
    logic [NCH*ABITS-1:0] m_a = '0;
    logic [SWBITS-1:0]    m_sw = '0;
    logic                 m_led = 1'b0;
    logic [7:0]           m_hist = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int code_of(input int v, input int mode);
        return (mode == 1) ? (v ^ (v >> 1)) : v;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_a = '0; m_sw = '0; m_led = 1'b0; m_hist = '0;
    endtask

    task automatic model_step(input int mode, input logic s);
        exp_t e;
        if (mode != 3) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                if (mode == 2) c = m_idx + k;
                else           c = code_of((m_idx + k) % (1 << IDXW), mode);
                m_a[k*ABITS +: ABITS] = ABITS'(c % (1 << ABITS));
            end
            if (mode == 2) m_sw = SWBITS'(1 << (m_idx % SWBITS));
            else           m_sw = SWBITS'(code_of(m_idx, mode) % (1 << SWBITS));
            m_idx = (m_idx + 1) % (1 << IDXW);
        end
        m_led = ~m_led;
        e.a = m_a; e.sw = m_sw; e.led = m_led; e.hist = m_hist;
        exp_q.push_back(e);
        m_hist = {m_hist[6:0], s};
    endtask

    task automatic do_step(input int mode, input logic s, input logic extra);
        MODE = 2'(mode); SENSE = s;
        model_step(mode, s);
        @(negedge CLK) STEP = 1'b1;
        @(negedge CLK) STEP = 1'b0;
        repeat (6) @(negedge CLK);
        // Now inside DWELL: a stray STEP and a MODE change must not disturb this step.
        MODE = 2'($urandom);
        if (extra) STEP = 1'b1;
        @(negedge CLK) STEP = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic do_run(input int n, input int mode, input logic s);
        MODE = 2'(mode); SENSE = s;
        for (int i = 0; i < n; i++) model_step(mode, s);
        @(negedge CLK) RUN = 1'b1;
        repeat (4) @(negedge CLK);
        STEP = 1'b1;
        @(negedge CLK) STEP = 1'b0;
        repeat (9 * n - 9) @(negedge CLK);
        RUN = 1'b0;
        repeat (12) @(negedge CLK);
    endtask

    // Scoreboard monitor
    logic prev_done = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && STEP_DONE) begin
            chk("done_pulse_width", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_step_done: got STEP_DONE=1 expected no step at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("mux_a",   32'(MUX_A),      32'(e.a));
                chk("sw_ctl",  32'(SW_CTL),     32'(e.sw));
                chk("led",     32'(LED),        32'(e.led));
                chk("hist",    32'(SENSE_HIST), 32'(e.hist));
                chk("en_dwell", 32'(MUX_EN),    32'(3'b111));
                chk("oe_dwell", 32'(OE_4094),   32'd1);
            end
        end
        prev_done = RST_N && STEP_DONE;
    end

    // Break-before-make gap length once the board is live
    int zrun = 0;
    always @(negedge CLK) begin
        if (!RST_N || !OE_4094) zrun = 0;
        else if (MUX_EN == '0) zrun++;
        else if (zrun != 0) begin
            chk("en_gap_len", 32'(zrun), 32'd5);
            zrun = 0;
        end
    end

    initial begin
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_en",   32'(MUX_EN), 32'd0);
        chk("rst_a",    32'(MUX_A), 32'd0);
        chk("rst_misc", 32'({SW_CTL, OE_4094, SENSE_HIST, STEP_DONE, LED, MON}), 32'd0);
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);
        chk("idle_en",   32'(MUX_EN), 32'd0);
        chk("idle_a",    32'(MUX_A), 32'd0);
        chk("idle_misc", 32'({SW_CTL, OE_4094, SENSE_HIST, STEP_DONE, LED, MON}), 32'd0);

        model_reset();
        for (int i = 0; i < 3; i++) do_step(0, 1'b1, i == 1);
        chk("hist_3steps", 32'(SENSE_HIST), 32'h07);
        chk("bin_idx2_a", 32'(MUX_A), 32'({3'd4, 3'd3, 3'd2}));

        for (int i = 0; i < 4; i++) do_step(0, 1'b0, 1'b0);
        do_step(1, 1'b1, 1'b0);
        chk("gray_idx7_sw", 32'(SW_CTL), 32'(4'b0100));
        chk("gray_idx7_ch1", 32'(MUX_A[5:3]), 32'd0);
        do_step(1, 1'b0, 1'b1);

        do_run(5, 2, 1'b1);
        do_run(3, 3, 1'b0);
        do_run(2, 1, 1'b1);

        for (int i = 0; i < 25; i++) begin
            int mode;
            logic s;
            mode = int'($urandom_range(0, 3));
            s = 1'($urandom);
            if ($urandom_range(0, 1) == 1) do_step(mode, s, 1'($urandom));
            else                           do_run(int'($urandom_range(1, 4)), mode, s);
        end

        // Reset in the middle of MAKE
        MODE = 2'b00; SENSE = 1'b1;
        @(negedge CLK) STEP = 1'b1;
        @(negedge CLK) STEP = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pre_rst_state", 32'(MON[2:0]), 32'd3);
        #1 RST_N = 1'b0;
        #1;
        chk("midrst_en",   32'(MUX_EN), 32'd0);
        chk("midrst_oe",   32'(OE_4094), 32'd0);
        chk("midrst_hist", 32'(SENSE_HIST), 32'd0);
        chk("midrst_mon",  32'(MON), 32'd0);
        model_reset();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        do_step(0, 1'b0, 1'b0);
        chk("post_rst_a", 32'(MUX_A), 32'({3'd2, 3'd1, 3'd0}));

        repeat (5) @(negedge CLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
